// File: rtl/x_lut7_cfg_loader.sv
`timescale 1ns/1ps
// Serial loader and active table for a 7-input LUT. Frames shift into a
// shadow register MSB first and are committed atomically to the active table.
//
//   state    | meaning
//   S_IDLE   | waiting for START, serial data ignored
//   S_LOAD   | shifting CDI into shadow on CDI_VALID
//   S_COMMIT | copy shadow to active, pulse DONE next cycle
module x_lut7_cfg_loader #(
  parameter logic [127:0] INIT       = 128'h0,
  parameter int           FRAME_BITS = 128
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       START,
  input  logic       CDI,
  input  logic       CDI_VALID,
  input  logic [6:0] ADR,
  output logic       O,
  output logic       CDO,
  output logic       BUSY,
  output logic       DONE,
  output logic [6:0] BIT_CNT
);

  localparam logic [6:0] LAST_BIT = 7'(FRAME_BITS - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_COMMIT
  } state_t;

  state_t         state, next_state;
  logic [127:0]   active_tbl;
  logic [127:0]   shadow_tbl;
  logic [6:0]     bit_cnt;
  logic           busy_q;
  logic           done_q;
  logic           shift_en;
  logic           cnt_clr;
  logic           commit_en;

  always_comb begin
    next_state = state;
    shift_en   = 1'b0;
    cnt_clr    = 1'b0;
    commit_en  = 1'b0;
    case (state)
      S_IDLE: begin
        if (START) begin
          next_state = S_LOAD;
          cnt_clr    = 1'b1;
        end
      end
      S_LOAD: begin
        // a restart discards the bit on the same edge
        if (START) begin
          cnt_clr = 1'b1;
        end else if (CDI_VALID) begin
          shift_en = 1'b1;
          if (bit_cnt == LAST_BIT) next_state = S_COMMIT;
        end
      end
      S_COMMIT: begin
        commit_en  = 1'b1;
        next_state = S_IDLE;
      end
      default: next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state      <= S_IDLE;
      active_tbl <= INIT;
      shadow_tbl <= INIT;
      bit_cnt    <= 7'd0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state  <= next_state;
      busy_q <= (next_state != S_IDLE);
      done_q <= commit_en;
      if (commit_en) active_tbl <= shadow_tbl;
      if (shift_en)  shadow_tbl <= {shadow_tbl[126:0], CDI};
      if (cnt_clr)
        bit_cnt <= 7'd0;
      else if (shift_en)
        bit_cnt <= bit_cnt + 7'd1;
    end
  end

  assign O       = active_tbl[ADR];
  assign CDO     = shadow_tbl[127];
  assign BUSY    = busy_q;
  assign DONE    = done_q;
  assign BIT_CNT = bit_cnt;

endmodule

// File: tb/tb_x_lut7_cfg_loader.sv
`timescale 1ns/1ps
// Directed bench for x_lut7_cfg_loader: reset, full, stalled, restarted,
// readback and reset-abandoned frame loads.
module tb_x_lut7_cfg_loader;

  localparam logic [127:0] INIT_V = 128'hA5;
  localparam logic [127:0] F_ENDS = 128'h8000_0000_0000_0000_0000_0000_0000_0001;
  localparam logic [127:0] F_0F   = 128'h0F;
  localparam logic [127:0] F_DB   = 128'hDEAD_BEEF;
  localparam logic [127:0] F_ONES = {128{1'b1}};

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic       START = 1'b0;
  logic       CDI = 1'b0;
  logic       CDI_VALID = 1'b0;
  logic [6:0] ADR = 7'd0;
  logic       O, CDO, BUSY, DONE;
  logic [6:0] BIT_CNT;

  int n_vec = 0;
  int n_err = 0;
  int done_cnt = 0;

  x_lut7_cfg_loader #(.INIT(INIT_V), .FRAME_BITS(128)) dut (
    .CLK(CLK), .RST(RST), .START(START), .CDI(CDI), .CDI_VALID(CDI_VALID),
    .ADR(ADR), .O(O), .CDO(CDO), .BUSY(BUSY), .DONE(DONE), .BIT_CNT(BIT_CNT)
  );

  always #5 CLK = ~CLK;

  always @(negedge CLK) if (DONE === 1'b1) done_cnt++;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // sweeps all addresses well inside one clock period
  task automatic read_table(output logic [127:0] t);
    t = '0;
    for (int i = 0; i < 128; i++) begin
      ADR = 7'(i);
      #0.05;
      t[i] = O;
    end
  endtask

  task automatic send_bits(input logic [127:0] f, input int n, input bit stall,
                           output logic [127:0] cap);
    cap = '0;
    for (int i = 0; i < n; i++) begin
      cap = {cap[126:0], CDO};
      CDI = f[127-i];
      CDI_VALID = 1'b1;
      tick();
      if (stall) begin
        CDI_VALID = 1'b0;
        CDI = ~CDI;
        tick();
        if (i < 127) chk("stall_hold", 128'(BIT_CNT), 128'(i + 1));
      end
    end
    CDI_VALID = 1'b0;
    CDI = 1'b0;
  endtask

  task automatic do_reset();
    RST = 1'b1;
    tick();
    RST = 1'b0;
  endtask

  task automatic do_start();
    START = 1'b1;
    tick();
    START = 1'b0;
  endtask

  logic [127:0] tbl, cap;
  int d0;

  initial begin
    tick();
    do_reset();

    // reset state
    chk("rst_busy", 128'(BUSY), 128'd0);
    chk("rst_done", 128'(DONE), 128'd0);
    chk("rst_cnt", 128'(BIT_CNT), 128'd0);
    chk("rst_cdo", 128'(CDO), 128'd0);
    read_table(tbl);
    chk("rst_table", tbl, INIT_V);
    CDI_VALID = 1'b1; CDI = 1'b1;
    tick(); tick();
    CDI_VALID = 1'b0; CDI = 1'b0;
    chk("idle_ignore_cnt", 128'(BIT_CNT), 128'd0);
    chk("idle_ignore_cdo", 128'(CDO), 128'd0);

    // full load with continuous valid: DONE appears 130 cycles after START
    d0 = done_cnt;
    do_start();
    chk("load_busy", 128'(BUSY), 128'd1);
    chk("load_cnt0", 128'(BIT_CNT), 128'd0);
    send_bits(F_ENDS, 64, 1'b0, cap);
    chk("mid_cnt", 128'(BIT_CNT), 128'd64);
    send_bits(F_ENDS << 64, 64, 1'b0, cap);
    chk("pre_done", 128'(DONE), 128'd0);
    chk("commit_busy", 128'(BUSY), 128'd1);
    chk("wrap_cnt", 128'(BIT_CNT), 128'd0);
    read_table(tbl);
    chk("pre_done_table", tbl, INIT_V);
    tick();
    chk("done_pulse", 128'(DONE), 128'd1);
    chk("done_busy", 128'(BUSY), 128'd0);
    read_table(tbl);
    chk("full_table", tbl, F_ENDS);
    tick();
    chk("done_drop", 128'(DONE), 128'd0);
    chk("full_done_cnt", 128'(done_cnt - d0), 128'd1);

    // stalled load of the same frame from a fresh reset
    do_reset();
    d0 = done_cnt;
    do_start();
    send_bits(F_ENDS, 128, 1'b1, cap);
    tick();
    chk("stall_done_cnt", 128'(done_cnt - d0), 128'd1);
    read_table(tbl);
    chk("stall_table", tbl, F_ENDS);

    // restart mid-frame discards the partial ones
    d0 = done_cnt;
    do_start();
    send_bits(F_ONES, 40, 1'b0, cap);
    chk("pre_restart_cnt", 128'(BIT_CNT), 128'd40);
    CDI = 1'b1; CDI_VALID = 1'b1;
    do_start();
    CDI_VALID = 1'b0;
    chk("restart_cnt", 128'(BIT_CNT), 128'd0);
    chk("restart_busy", 128'(BUSY), 128'd1);
    send_bits(F_0F, 128, 1'b0, cap);
    tick(); tick();
    chk("restart_done_cnt", 128'(done_cnt - d0), 128'd1);
    read_table(tbl);
    chk("restart_table", tbl, F_0F);

    // readback: second load shifts out the previous frame on CDO
    do_start();
    send_bits(F_DB, 128, 1'b0, cap);
    tick();
    chk("db_done", 128'(DONE), 128'd1);
    read_table(tbl);
    chk("db_table", tbl, F_DB);
    do_start();
    send_bits(128'h0, 128, 1'b0, cap);
    chk("readback_cdo", cap, F_DB);
    tick();
    read_table(tbl);
    chk("zero_table", tbl, 128'h0);

    // reset mid-load abandons the frame and restores INIT
    d0 = done_cnt;
    do_start();
    send_bits(F_ONES, 64, 1'b0, cap);
    chk("abort_cnt64", 128'(BIT_CNT), 128'd64);
    do_reset();
    chk("abort_busy", 128'(BUSY), 128'd0);
    chk("abort_cnt", 128'(BIT_CNT), 128'd0);
    chk("abort_cdo", 128'(CDO), 128'd0);
    read_table(tbl);
    chk("abort_table", tbl, INIT_V);
    CDI = 1'b1; CDI_VALID = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    CDI_VALID = 1'b0; CDI = 1'b0;
    chk("abort_no_start_cnt", 128'(BIT_CNT), 128'd0);
    chk("abort_no_done", 128'(done_cnt - d0), 128'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
